// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM encoding and requester IDs.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } arb_state_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DMA = 1'b1;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin pick: a lone eligible requester wins, a tie goes to the one not granted last.
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic [1:0] eligible,
  input  logic       last,
  output logic       grant_valid,
  output logic       grant_id
);

  always_comb begin
    grant_valid = |eligible;
    grant_id    = REQ_CPU;
    case (eligible)
      2'b01:   grant_id = REQ_CPU;
      2'b10:   grant_id = REQ_DMA;
      2'b11:   grant_id = ~last;
      default: grant_id = REQ_CPU;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous memory port between the CPU and DMA requesters,
// sequencing each byte through an address phase and a data phase.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic              cpu_lock,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic              dma_lock,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ack,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_out,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_in
);

  arb_state_t state;
  logic       owner;
  logic       last;
  logic       lock_r;
  logic       cur_we;

  logic       owner_lock;
  logic       lock_eff;
  logic [1:0] eligible;
  logic       grant_valid;
  logic       grant_id;

  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              win_we;

  // A requester is masked while it owns the data phase or while its ack is
  // still showing, so a request held into the ack cycle is not issued twice.
  // A locked owner is let back in during its ack cycle; the other side waits.
  function automatic logic is_eligible(
    input logic       req,
    input logic       ack,
    input logic       id,
    input arb_state_t st,
    input logic       own,
    input logic       lk
  );
    logic busy;
    logic owns;
    owns = (own == id);
    busy = (st == ST_DATA) && owns;
    is_eligible = req && !busy && (!ack || (lk && owns)) && !(lk && !owns);
  endfunction

  assign owner_lock = (owner == REQ_DMA) ? dma_lock : cpu_lock;
  // The lock decided at the end of this data phase already blocks the other side now.
  assign lock_eff   = (state == ST_DATA) ? owner_lock : lock_r;

  assign eligible[REQ_CPU] = is_eligible(cpu_req, cpu_ack, REQ_CPU, state, owner, lock_eff);
  assign eligible[REQ_DMA] = is_eligible(dma_req, dma_ack, REQ_DMA, state, owner, lock_eff);

  arb_rr2 u_rr (
    .eligible    (eligible),
    .last        (last),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign win_addr  = (grant_id == REQ_DMA) ? dma_addr  : cpu_addr;
  assign win_wdata = (grant_id == REQ_DMA) ? dma_wdata : cpu_wdata;
  assign win_we    = (grant_id == REQ_DMA) ? dma_we    : cpu_we;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      owner       <= REQ_CPU;
      last        <= REQ_DMA;
      lock_r      <= 1'b0;
      cur_we      <= 1'b0;
      mem_address <= '0;
      mem_out     <= '0;
      mem_wren    <= 1'b0;
      cpu_ack     <= 1'b0;
      dma_ack     <= 1'b0;
      cpu_rdata   <= '0;
      dma_rdata   <= '0;
    end else begin
      cpu_ack <= 1'b0;
      dma_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            state       <= ST_ADDR;
            owner       <= grant_id;
            last        <= grant_id;
            cur_we      <= win_we;
            mem_address <= win_addr;
            mem_out     <= win_wdata;
            mem_wren    <= win_we;
          end
        end
        ST_ADDR: begin
          state    <= ST_DATA;
          mem_wren <= 1'b0;
        end
        ST_DATA: begin
          lock_r <= owner_lock;
          if (owner == REQ_DMA) begin
            dma_ack <= 1'b1;
            if (!cur_we) dma_rdata <= mem_in;
          end else begin
            cpu_ack <= 1'b1;
            if (!cur_we) cpu_rdata <= mem_in;
          end
          if (grant_valid) begin
            state       <= ST_ADDR;
            owner       <= grant_id;
            last        <= grant_id;
            cur_we      <= win_we;
            mem_address <= win_addr;
            mem_out     <= win_wdata;
            mem_wren    <= win_we;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state    <= ST_IDLE;
          mem_wren <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single reads/writes, alternation, lock, held requests, async reset.
module tb_mem_arbiter;

  logic        clock;
  logic        resetn;
  logic        cpu_req, cpu_we, cpu_lock;
  logic [19:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        cpu_ack;
  logic        dma_req, dma_we, dma_lock;
  logic [19:0] dma_addr;
  logic [7:0]  dma_wdata, dma_rdata;
  logic        dma_ack;
  logic [19:0] mem_address;
  logic [7:0]  mem_out;
  logic        mem_wren;
  logic [7:0]  mem_in;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.ADDR_W(20), .DATA_W(8)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_lock    (cpu_lock),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_ack     (cpu_ack),
    .dma_req     (dma_req),
    .dma_we      (dma_we),
    .dma_lock    (dma_lock),
    .dma_addr    (dma_addr),
    .dma_wdata   (dma_wdata),
    .dma_rdata   (dma_rdata),
    .dma_ack     (dma_ack),
    .mem_address (mem_address),
    .mem_out     (mem_out),
    .mem_wren    (mem_wren),
    .mem_in      (mem_in)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_lock = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_lock = 0; dma_addr = '0; dma_wdata = '0;
    mem_in = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    resetn = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    resetn = 1'b1;
  endtask

  int nw, na;

  initial begin
    idle_inputs();
    resetn = 1'b1;
    #2 resetn = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_addr",  mem_address, 0);
    check("rst_out",   mem_out, 0);
    check("rst_wren",  mem_wren, 0);
    check("rst_cack",  cpu_ack, 0);
    check("rst_dack",  dma_ack, 0);
    check("rst_crd",   cpu_rdata, 0);
    check("rst_drd",   dma_rdata, 0);
    resetn = 1'b1;
    tick();

    // CPU read 0x12345
    cpu_we = 0; cpu_addr = 20'h12345; cpu_req = 1;
    tick();
    check("rd_addr", mem_address, 20'h12345);
    check("rd_wren", mem_wren, 0);
    tick();
    mem_in = 8'hA5;
    check("rd_noack_data", cpu_ack, 0);
    tick();
    check("rd_ack", cpu_ack, 1);
    check("rd_data", cpu_rdata, 8'hA5);
    check("rd_dack", dma_ack, 0);
    cpu_req = 0; mem_in = 0;
    tick();
    check("rd_ack_pulse", cpu_ack, 0);

    // CPU write 0x00400 = 0x3C
    cpu_we = 1; cpu_addr = 20'h00400; cpu_wdata = 8'h3C; cpu_req = 1;
    tick();
    check("wr_wren", mem_wren, 1);
    check("wr_out", mem_out, 8'h3C);
    check("wr_addr", mem_address, 20'h00400);
    tick();
    check("wr_wren_drop", mem_wren, 0);
    mem_in = 8'hFF;
    tick();
    check("wr_ack", cpu_ack, 1);
    check("wr_rdata_kept", cpu_rdata, 8'hA5);
    cpu_req = 0; cpu_we = 0; mem_in = 0;
    tick();

    // Both requesting from reset: CPU, DMA, CPU, DMA
    do_reset();
    cpu_addr = 20'h11111; dma_addr = 20'h22222; cpu_req = 1; dma_req = 1;
    mem_in = 8'h40;
    for (int k = 1; k <= 9; k++) begin
      tick();
      mem_in = 8'h40 + 8'(k);
      if (k % 2 == 1)
        check($sformatf("rr_addr_c%0d", k), mem_address, (k % 4 == 1) ? 20'h11111 : 20'h22222);
      check($sformatf("rr_cack_c%0d", k), cpu_ack, (k == 3 || k == 7) ? 1 : 0);
      check($sformatf("rr_dack_c%0d", k), dma_ack, (k == 5 || k == 9) ? 1 : 0);
      if (k == 3) check("rr_crd_3", cpu_rdata, 8'h42);
      if (k == 5) check("rr_drd_5", dma_rdata, 8'h44);
      if (k == 7) check("rr_crd_7", cpu_rdata, 8'h46);
    end
    cpu_req = 0; dma_req = 0;
    repeat (4) tick();

    // Locked two-byte CPU write while DMA waits
    do_reset();
    cpu_req = 1; cpu_we = 1; cpu_lock = 1; cpu_addr = 20'h00100; cpu_wdata = 8'hAA;
    dma_req = 1; dma_we = 0; dma_addr = 20'h55555;
    tick();
    check("lk_addr1", mem_address, 20'h00100);
    check("lk_wren1", mem_wren, 1);
    check("lk_out1", mem_out, 8'hAA);
    tick();
    check("lk_wren1_drop", mem_wren, 0);
    tick();
    check("lk_cack1", cpu_ack, 1);
    check("lk_no_switch", mem_address, 20'h00100);
    check("lk_dack_t3", dma_ack, 0);
    cpu_addr = 20'h00101; cpu_wdata = 8'hBB; cpu_lock = 0;
    tick();
    check("lk_addr2", mem_address, 20'h00101);
    check("lk_out2", mem_out, 8'hBB);
    check("lk_wren2", mem_wren, 1);
    tick();
    tick();
    check("lk_cack2", cpu_ack, 1);
    check("lk_dma_addr", mem_address, 20'h55555);
    check("lk_dma_wren", mem_wren, 0);
    cpu_req = 0; cpu_we = 0;
    tick();
    mem_in = 8'h77;
    tick();
    check("lk_dack", dma_ack, 1);
    check("lk_drd", dma_rdata, 8'h77);
    check("lk_cack_off", cpu_ack, 0);
    dma_req = 0; mem_in = 0;
    tick();

    // Request held through its ack cycle: one access, one ack
    cpu_req = 1; cpu_we = 1; cpu_addr = 20'h0ABCD; cpu_wdata = 8'h5A;
    nw = 0; na = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (mem_wren) nw++;
      if (cpu_ack) na++;
      if (k == 4) cpu_req = 0;
    end
    check("hold_wren_count", nw, 1);
    check("hold_ack_count", na, 1);
    cpu_we = 0;

    // Async reset during the address phase of a DMA write
    dma_req = 1; dma_we = 1; dma_addr = 20'h33333; dma_wdata = 8'h99;
    tick();
    check("ar_wren_before", mem_wren, 1);
    #2 resetn = 1'b0;
    #1;
    check("ar_wren_async", mem_wren, 0);
    check("ar_addr_async", mem_address, 0);
    cpu_req = 1; cpu_we = 0; cpu_addr = 20'h44444;
    @(posedge clock);
    #1;
    check("ar_dack_in_reset", dma_ack, 0);
    resetn = 1'b1;
    tick();
    check("ar_tie_cpu", mem_address, 20'h44444);
    check("ar_no_dack", dma_ack, 0);
    check("ar_wren_read", mem_wren, 0);
    cpu_req = 0; dma_req = 0;
    repeat (6) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
